// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: a main output register plus one skid entry, so upstream ready
// comes from a flop and never depends combinationally on downstream ready.
module pipe_stage_skid #(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE  = '0,
  parameter logic [DATA_WIDTH-1:0]  BUBBLE_VALUE = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic                  ready_q,      ready_d;
  logic [1:0]            count_q,      count_d;

  logic accept;
  logic take;

  assign accept = i_valid & ready_q;
  assign take   = main_valid_q & i_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (i_flush) begin
      // A beat accepted this cycle is dropped; a take this cycle already completed.
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE_VALUE;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || take) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = i_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = i_data;
    end

    ready_d = ~skid_valid_d;
    count_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= RESET_VALUE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= RESET_VALUE;
      ready_q      <= 1'b1;
      count_q      <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
      count_q      <= count_d;
    end
  end

  assign o_valid = main_valid_q;
  assign o_data  = main_data_q;
  assign o_ready = ready_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed vector table for pipe_stage_skid followed by a randomised run checked
// against a queue of beats the stage should currently be holding.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        i_reset, i_flush, i_valid, i_ready;
  logic [31:0] i_data;
  logic        o_ready, o_valid;
  logic [31:0] o_data;
  logic [1:0]  o_count;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_skid dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, v, r;
    logic [31:0] d;
    logic        e_valid, e_ready;
    logic [31:0] e_data;
    logic [1:0]  e_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, fl, v, r, input logic [31:0] d,
                     input logic ev, er, input logic [31:0] ed, input logic [1:0] ec);
    vec_t t;
    t.rst = rst; t.fl = fl; t.v = v; t.r = r; t.d = d;
    t.e_valid = ev; t.e_ready = er; t.e_data = ed; t.e_count = ec;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock, then sample just after the edge.
  task automatic step(input logic rst, fl, v, r, input logic [31:0] d);
    i_reset = rst; i_flush = fl; i_valid = v; i_ready = r; i_data = d;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;

    //   rst fl v  r  data           ov or  odata          cnt
    add(1, 0, 1, 0, 32'hAAAA_AAAA, 0, 1, 32'h0,         0);  // reset held
    add(1, 0, 1, 0, 32'hAAAA_AAAA, 0, 1, 32'h0,         0);
    add(0, 0, 1, 1, 32'h1,         1, 1, 32'h1,         1);  // streaming
    add(0, 0, 1, 1, 32'h2,         1, 1, 32'h2,         1);
    add(0, 0, 1, 1, 32'h3,         1, 1, 32'h3,         1);
    add(0, 0, 1, 1, 32'h4,         1, 1, 32'h4,         1);
    add(0, 0, 0, 1, 32'h0,         0, 1, 32'h4,         0);  // drained, data held
    add(0, 0, 0, 1, 32'h0,         0, 1, 32'h4,         0);  // empty + ready: no effect
    add(0, 0, 1, 1, 32'h10,        1, 1, 32'h10,        1);  // back-pressure
    add(0, 0, 1, 0, 32'h11,        1, 0, 32'h10,        2);
    add(0, 0, 1, 1, 32'h12,        1, 1, 32'h11,        1);
    add(0, 0, 1, 1, 32'h12,        1, 1, 32'h12,        1);
    add(0, 0, 0, 1, 32'h0,         0, 1, 32'h12,        0);
    add(0, 0, 1, 0, 32'h20,        1, 1, 32'h20,        1);  // full hold
    add(0, 0, 1, 0, 32'h21,        1, 0, 32'h20,        2);
    add(0, 0, 1, 0, 32'h22,        1, 0, 32'h20,        2);
    add(0, 0, 1, 0, 32'h22,        1, 0, 32'h20,        2);
    add(0, 0, 1, 0, 32'h22,        1, 0, 32'h20,        2);
    add(0, 0, 1, 0, 32'h22,        1, 0, 32'h20,        2);
    add(0, 0, 0, 1, 32'h0,         1, 1, 32'h21,        1);
    add(0, 0, 0, 1, 32'h0,         0, 1, 32'h21,        0);
    add(0, 0, 1, 0, 32'h30,        1, 1, 32'h30,        1);  // flush when full
    add(0, 0, 1, 0, 32'h31,        1, 0, 32'h30,        2);
    add(0, 1, 1, 0, 32'h55,        0, 1, 32'h13,        0);
    add(0, 0, 0, 0, 32'h0,         0, 1, 32'h13,        0);
    add(0, 0, 1, 1, 32'h40,        1, 1, 32'h40,        1);  // flush + reset
    add(1, 1, 1, 1, 32'h41,        0, 1, 32'h0,         0);
    add(0, 0, 1, 0, 32'h50,        1, 1, 32'h50,        1);  // reset mid-operation
    add(0, 0, 1, 0, 32'h51,        1, 0, 32'h50,        2);
    add(1, 0, 1, 0, 32'h52,        0, 1, 32'h0,         0);
    add(0, 0, 1, 1, 32'h60,        1, 1, 32'h60,        1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].fl, vecs[i].v, vecs[i].r, vecs[i].d);
      check($sformatf("vec%0d o_valid", i), {31'b0, o_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d o_ready", i), {31'b0, o_ready}, {31'b0, vecs[i].e_ready});
      check($sformatf("vec%0d o_data", i),  o_data,           vecs[i].e_data);
      check($sformatf("vec%0d o_count", i), {30'b0, o_count}, {30'b0, vecs[i].e_count});
    end

    // Randomised traffic against a queue of beats held by the stage.
    step(1, 0, 0, 0, 32'h0);
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic v, r, fl, acc, tk;
      logic [31:0] d;
      v  = ($urandom_range(3) != 0);
      r  = ($urandom_range(2) != 0);
      fl = ($urandom_range(31) == 0);
      d  = $urandom;
      acc = v & (q.size() < 2);
      tk  = r & (q.size() > 0);
      if (tk) check("rand take data", o_data, q[0]);
      step(0, fl, v, r, d);
      if (tk) void'(q.pop_front());
      if (fl) q.delete();
      else if (acc) q.push_back(d);
      check("rand o_count", {30'b0, o_count}, q.size());
      check("rand o_valid", {31'b0, o_valid}, {31'b0, q.size() > 0});
      check("rand o_ready", {31'b0, o_ready}, {31'b0, q.size() < 2});
      check("rand no X", {31'b0, $isunknown({o_valid, o_ready, o_data, o_count})}, 32'h0);
      if (fl) check("rand flush bubble", o_data, 32'h0000_0013);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
